// File: rtl/multi_dataflow_ctrl_fsm_pkg.sv
// Shared types and sizing for the multi_dataflow control FSM.
// Engine ctrl/flags bundles live here so engine and controller agree.
package multi_dataflow_ctrl_fsm_pkg;

   localparam int unsigned CNT_LEN = 1024;
   localparam int unsigned CNT_W   = $clog2(CNT_LEN) + 2;
   localparam int unsigned N_COEFF = 4;
   localparam int unsigned COEFF_W = 32;
   localparam int unsigned TIMEOUT = 4096;
   localparam int unsigned CFG_W   = N_COEFF * COEFF_W;

   typedef enum logic [2:0] {
      IDLE,
      START,
      COMPUTE,
      FLUSH,
      FINISH
   } ctrl_fsm_state_t;

   typedef struct packed {
      logic                              start;
      logic                              clear;
      logic [N_COEFF-1:0][COEFF_W-1:0]   coeff;
   } ctrl_engine_t;

   typedef struct packed {
      logic              ready;
      logic              done;
      logic [CNT_W-1:0]  cnt_outStream0;
   } flags_engine_t;

   typedef struct packed {
      logic [CNT_W-1:0]                  len;
      logic [N_COEFF-1:0][COEFF_W-1:0]   coeff;
   } ctrl_fsm_cfg_t;

endpackage

// File: rtl/multi_dataflow_ctrl_fsm_if.sv
// Control/flag bundle between register file, streamers, engine and FSM.
// The FSM is the slave; the surrounding HWPE logic is the master.
interface multi_dataflow_ctrl_fsm_if;
   import multi_dataflow_ctrl_fsm_pkg::*;

   logic              clear_i;
   logic              trigger_i;
   logic [CNT_W-1:0]  len_i;
   logic [CFG_W-1:0]  coeff_i;
   logic              in_ready_i;
   logic              out_ready_i;
   logic              out_done_i;
   logic              eng_ready_i;
   logic [CNT_W-1:0]  eng_cnt_i;
   logic              in_start_o;
   logic              out_start_o;
   logic              eng_start_o;
   logic              eng_clear_o;
   logic [CFG_W-1:0]  eng_coeff_o;
   logic              busy_o;
   logic              evt_done_o;
   logic              err_o;

   modport slave (
      input  clear_i, trigger_i, len_i, coeff_i,
      input  in_ready_i, out_ready_i, out_done_i,
      input  eng_ready_i, eng_cnt_i,
      output in_start_o, out_start_o, eng_start_o,
      output eng_clear_o, eng_coeff_o,
      output busy_o, evt_done_o, err_o
   );

   modport master (
      output clear_i, trigger_i, len_i, coeff_i,
      output in_ready_i, out_ready_i, out_done_i,
      output eng_ready_i, eng_cnt_i,
      input  in_start_o, out_start_o, eng_start_o,
      input  eng_clear_o, eng_coeff_o,
      input  busy_o, evt_done_o, err_o
   );

endinterface

// File: rtl/multi_dataflow_ctrl_fsm_watchdog.sv
// Loadable down-counter: reloads on kick, expires after TIMEOUT
// consecutive enabled cycles without a reload.
module multi_dataflow_watchdog #(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned W = $clog2(TIMEOUT) + 1;
   localparam logic [W-1:0] TOP = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q;

   // reload on clear/kick, otherwise count down while enabled
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= TOP;
      end else if (clear_i || load_i) begin
         cnt_q <= TOP;
      end else if (en_i && cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expire_o = en_i & ~load_i & (cnt_q == '0);

endmodule

// File: rtl/multi_dataflow_ctrl_fsm.sv
// Job sequencer for the multi_dataflow engine: launch, track output
// count, wait for sink drain, then signal done (or error/abort).
module multi_dataflow_ctrl_fsm #(
   parameter int unsigned TIMEOUT = multi_dataflow_ctrl_fsm_pkg::TIMEOUT
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   multi_dataflow_ctrl_fsm_if.slave    io
);
   import multi_dataflow_ctrl_fsm_pkg::*;

   ctrl_fsm_state_t  state_q;
   ctrl_fsm_cfg_t    cfg_q;
   logic             pending_q;
   logic             out_done_q;
   logic             err_q;
   logic             busy_q;
   logic             in_start_q;
   logic             out_start_q;
   logic             eng_start_q;
   logic             eng_clear_q;
   logic             evt_done_q;
   logic [CNT_W-1:0] cnt_q;

   logic             go;
   logic             all_rdy;
   logic             len_zero;
   logic             active;
   logic             kick;
   logic             expire;
   logic [CNT_W-1:0] len_nxt;

   assign go       = pending_q | io.trigger_i;
   assign len_nxt  = io.trigger_i ? io.len_i : cfg_q.len;
   assign len_zero = (len_nxt == '0);
   assign all_rdy  = io.in_ready_i & io.out_ready_i & io.eng_ready_i;
   assign active   = (state_q == COMPUTE) | (state_q == FLUSH);
   assign kick     = (io.eng_cnt_i != cnt_q);

   multi_dataflow_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) i_wdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (io.clear_i),
      .load_i   (~active | kick),
      .en_i     (active),
      .expire_o (expire)
   );

   // state register, config latch, sticky flags and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cfg_q       <= '0;
         pending_q   <= 1'b0;
         out_done_q  <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         in_start_q  <= 1'b0;
         out_start_q <= 1'b0;
         eng_start_q <= 1'b0;
         eng_clear_q <= 1'b0;
         evt_done_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         cnt_q       <= io.eng_cnt_i;
         in_start_q  <= 1'b0;
         out_start_q <= 1'b0;
         eng_start_q <= 1'b0;
         eng_clear_q <= 1'b0;
         evt_done_q  <= 1'b0;
         if (io.clear_i) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            out_done_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            eng_clear_q <= 1'b0 | 1'b1;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (io.trigger_i) begin
                     cfg_q <= {io.len_i, io.coeff_i};
                  end
                  if (go && len_zero) begin
                     state_q     <= FINISH;
                     pending_q   <= 1'b0;
                     err_q       <= 1'b0;
                     busy_q      <= 1'b1;
                     evt_done_q  <= 1'b1;
                     eng_clear_q <= 1'b1;
                  end else if (go && all_rdy) begin
                     state_q     <= START;
                     pending_q   <= 1'b0;
                     err_q       <= 1'b0;
                     out_done_q  <= 1'b0;
                     busy_q      <= 1'b1;
                     in_start_q  <= 1'b1;
                     out_start_q <= 1'b1;
                     eng_start_q <= 1'b1;
                  end else begin
                     pending_q <= go;
                  end
               end
               START: begin
                  state_q <= COMPUTE;
               end
               COMPUTE: begin
                  if (io.out_done_i) begin
                     out_done_q <= 1'b1;
                  end
                  if (io.eng_cnt_i > cfg_q.len) begin
                     err_q <= 1'b1;
                  end
                  if (io.eng_cnt_i >= cfg_q.len) begin
                     state_q <= FLUSH;
                  end else if (expire) begin
                     state_q     <= FINISH;
                     err_q       <= 1'b1;
                     evt_done_q  <= 1'b1;
                     eng_clear_q <= 1'b1;
                  end
               end
               FLUSH: begin
                  if (io.out_done_i || out_done_q) begin
                     state_q     <= FINISH;
                     evt_done_q  <= 1'b1;
                     eng_clear_q <= 1'b1;
                  end else if (expire) begin
                     state_q     <= FINISH;
                     err_q       <= 1'b1;
                     evt_done_q  <= 1'b1;
                     eng_clear_q <= 1'b1;
                  end
               end
               FINISH: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign io.in_start_o  = in_start_q;
   assign io.out_start_o = out_start_q;
   assign io.eng_start_o = eng_start_q;
   assign io.eng_clear_o = eng_clear_q;
   assign io.eng_coeff_o = cfg_q.coeff;
   assign io.busy_o      = busy_q;
   assign io.evt_done_o  = evt_done_q;
   assign io.err_o       = err_q;

endmodule

// File: tb/tb_multi_dataflow_ctrl_fsm.sv
// Directed bench for multi_dataflow_ctrl_fsm: vector table plus
// hand sequences for deferred launch, early done, timeout and reset.
module tb_multi_dataflow_ctrl_fsm;
   import multi_dataflow_ctrl_fsm_pkg::*;

   localparam logic [6:0] Z = 7'b0000000;
   localparam logic [6:0] S = 7'b1111000;
   localparam logic [6:0] B = 7'b0001000;
   localparam logic [6:0] F = 7'b0001110;
   localparam logic [6:0] E = 7'b0000001;
   localparam logic [6:0] C = 7'b0000010;

   localparam logic [CFG_W-1:0] CO_A = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [CFG_W-1:0] CO_B = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;

   typedef struct {
      logic        trig;
      logic        clr;
      int          len;
      logic        done;
      int          cnt;
      logic [6:0]  exp;
   } vec_t;

   logic clk;
   logic rst_ni;
   int   n_tests;
   int   n_fail;
   vec_t tbl[$];

   multi_dataflow_ctrl_fsm_if dif ();

   multi_dataflow_ctrl_fsm #(
      .TIMEOUT (16)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .io     (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] obs();
      return {dif.in_start_o, dif.out_start_o, dif.eng_start_o,
              dif.busy_o, dif.evt_done_o, dif.eng_clear_o, dif.err_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [CFG_W-1:0] act,
                        input logic [CFG_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic t, input logic c, input int len,
                      input logic d, input int cnt, input logic [6:0] e);
      vec_t v;
      v.trig = t; v.clr = c; v.len = len;
      v.done = d; v.cnt = cnt; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic t, input logic c, input int len,
                        input logic d, input int cnt);
      dif.trigger_i  = t;
      dif.clear_i    = c;
      dif.len_i      = CNT_W'(len);
      dif.out_done_i = d;
      dif.eng_cnt_i  = CNT_W'(cnt);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_ni  = 1'b0;
      drive(0, 0, 0, 0, 0);
      dif.coeff_i     = CO_A;
      dif.in_ready_i  = 1'b1;
      dif.out_ready_i = 1'b1;
      dif.eng_ready_i = 1'b1;

      // nominal len=8, busy trigger ignored, no queued job
      add(0, 0, 0, 0, 0, Z);
      add(1, 0, 8, 0, 0, S);
      add(0, 0, 8, 0, 0, B);
      add(1, 0, 0, 0, 4, B);
      add(0, 0, 8, 0, 8, B);
      add(0, 0, 8, 1, 8, F);
      add(0, 0, 8, 0, 8, Z);
      add(0, 0, 8, 0, 8, Z);
      // len=0: straight to FINISH
      add(1, 0, 0, 0, 0, F);
      add(0, 0, 0, 0, 0, Z);
      // overrun, sticky err, cleared by next launch
      add(1, 0, 8, 0, 0, S);
      add(0, 0, 8, 0, 0, B);
      add(0, 0, 8, 0, 9, B | E);
      add(0, 0, 8, 1, 9, F | E);
      add(0, 0, 8, 0, 9, E);
      add(1, 0, 4, 0, 0, S);
      add(0, 0, 4, 0, 0, B);
      add(0, 0, 4, 1, 4, B);
      add(0, 0, 4, 0, 4, F);
      add(0, 0, 4, 0, 4, Z);
      // clear in COMPUTE with simultaneous trigger
      add(1, 0, 8, 0, 0, S);
      add(0, 0, 8, 0, 0, B);
      add(0, 0, 8, 0, 2, B);
      add(1, 1, 8, 0, 2, C);
      add(0, 0, 8, 0, 2, Z);
      add(0, 0, 8, 0, 2, Z);

      #12;
      check("reset_outputs", CFG_W'(obs()), CFG_W'(Z));
      check("reset_coeff", dif.eng_coeff_o, '0);
      @(negedge clk);
      rst_ni = 1'b1;
      #1;
      check("post_reset_outputs", CFG_W'(obs()), CFG_W'(Z));

      foreach (tbl[i]) begin
         drive(tbl[i].trig, tbl[i].clr, tbl[i].len, tbl[i].done, tbl[i].cnt);
         tick();
         check($sformatf("vec%0d", i), CFG_W'(obs()), CFG_W'(tbl[i].exp));
      end
      drive(0, 0, 0, 0, 0);

      // deferred launch: engine not ready, coeff changes after trigger
      dif.coeff_i     = CO_A;
      dif.eng_ready_i = 1'b0;
      drive(1, 0, 8, 0, 0);
      tick();
      check("defer_pending", CFG_W'(obs()), CFG_W'(Z));
      drive(0, 0, 0, 0, 0);
      dif.coeff_i = CO_B;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("defer_wait%0d", i), CFG_W'(obs()), CFG_W'(Z));
      end
      dif.eng_ready_i = 1'b1;
      tick();
      check("defer_start", CFG_W'(obs()), CFG_W'(S));
      check("defer_coeff", dif.eng_coeff_o, CO_A);
      tick();
      drive(0, 0, 0, 0, 8);
      tick();
      check("defer_flush", CFG_W'(obs()), CFG_W'(B));
      check("defer_coeff_hold", dif.eng_coeff_o, CO_A);
      drive(0, 0, 0, 1, 8);
      tick();
      check("defer_finish", CFG_W'(obs()), CFG_W'(F));
      drive(0, 0, 0, 0, 8);
      tick();
      check("defer_idle", CFG_W'(obs()), CFG_W'(Z));

      // early out_done at cnt=5 of 8
      drive(1, 0, 8, 0, 0);
      tick();
      check("early_start", CFG_W'(obs()), CFG_W'(S));
      drive(0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 5);
      tick();
      check("early_done_seen", CFG_W'(obs()), CFG_W'(B));
      drive(0, 0, 0, 0, 8);
      tick();
      check("early_flush", CFG_W'(obs()), CFG_W'(B));
      tick();
      check("early_finish", CFG_W'(obs()), CFG_W'(F));
      tick();
      check("early_idle", CFG_W'(obs()), CFG_W'(Z));

      // timeout: count stalls at 3
      drive(1, 0, 8, 0, 0);
      tick();
      check("to_start", CFG_W'(obs()), CFG_W'(S));
      drive(0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 3);
      tick();
      for (int i = 1; i <= 16; i++) begin
         tick();
         check($sformatf("to_stall%0d", i), CFG_W'(obs()),
               CFG_W'((i == 16) ? (F | E) : B));
      end
      tick();
      check("to_sticky", CFG_W'(obs()), CFG_W'(E));
      drive(1, 0, 8, 0, 0);
      tick();
      check("to_relaunch", CFG_W'(obs()), CFG_W'(S));
      drive(0, 1, 0, 0, 0);
      tick();
      check("to_abort", CFG_W'(obs()), CFG_W'(C));
      drive(0, 0, 0, 0, 0);
      tick();
      check("to_abort_idle", CFG_W'(obs()), CFG_W'(Z));

      // async reset mid-job
      dif.coeff_i = CO_B;
      drive(1, 0, 8, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      tick();
      check("rst_busy", CFG_W'(obs()), CFG_W'(B));
      #2;
      rst_ni = 1'b0;
      #1;
      check("rst_async", CFG_W'(obs()), CFG_W'(Z));
      check("rst_coeff", dif.eng_coeff_o, '0);
      tick();
      rst_ni = 1'b1;
      tick();
      check("rst_idle", CFG_W'(obs()), CFG_W'(Z));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
